// File: rtl/palette_lut_banked_if.sv
// Palette lookup bus: frame-synchronous bank select, pixel-index lookup
// request and response, and the runtime palette write port.
//   master : drives frame_start, bank_sel, rd_valid, rd_index, wr_en,
//            wr_bank, wr_index, wr_data; observes the response signals
//   slave  : the palette itself; drives out_valid, red, green, blue,
//            transparent, wr_ready, init_done
interface palette_lut_banked_if #(
  parameter int IDX_W  = 4,
  parameter int COMP_W = 4,
  parameter int BANK_W = 2
);
  logic                  frame_start;
  logic [BANK_W-1:0]     bank_sel;
  logic                  rd_valid;
  logic [IDX_W-1:0]      rd_index;
  logic                  out_valid;
  logic [COMP_W-1:0]     red;
  logic [COMP_W-1:0]     green;
  logic [COMP_W-1:0]     blue;
  logic                  transparent;
  logic                  wr_en;
  logic [BANK_W-1:0]     wr_bank;
  logic [IDX_W-1:0]      wr_index;
  logic [3*COMP_W-1:0]   wr_data;
  logic                  wr_ready;
  logic                  init_done;

  modport master (
    output frame_start, bank_sel, rd_valid, rd_index,
           wr_en, wr_bank, wr_index, wr_data,
    input  out_valid, red, green, blue, transparent, wr_ready, init_done
  );

  modport slave (
    input  frame_start, bank_sel, rd_valid, rd_index,
           wr_en, wr_bank, wr_index, wr_data,
    output out_valid, red, green, blue, transparent, wr_ready, init_done
  );
endinterface

// File: rtl/palette_lut_banked.sv
// Runtime-writable multi-bank sprite palette. Maps a pixel index to an
// {R,G,B} colour through the active bank with a fixed one-cycle latency,
// flags the transparent key index, and switches banks only on frame_start.
// After reset an init sequencer fills every entry with DEFAULT_RGB before
// reads and writes are accepted.
// Ports:
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : palette_lut_banked_if.slave (lookup, bank select, write port)
module palette_lut_banked #(
  parameter int                  IDX_W           = 4,
  parameter int                  COMP_W          = 4,
  parameter int                  NUM_BANKS       = 4,
  parameter logic [3*COMP_W-1:0] DEFAULT_RGB     = 12'h6AF,
  parameter int                  TRANSPARENT_IDX = 0,
  parameter bit                  TRANS_EN        = 1'b1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  palette_lut_banked_if.slave    bus
);

  localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int DEPTH   = NUM_BANKS * ENTRIES;
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RGB_W   = 3 * COMP_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic [ADDR_W-1:0]   w_init_cnt_nxt;
  logic                r_ready;

  logic [BANK_W-1:0]   r_active_bank;
  logic [BANK_W-1:0]   r_pending_bank;

  logic [RGB_W-1:0]    r_mem [0:DEPTH-1];

  logic                r_out_valid;
  logic [RGB_W-1:0]    r_rgb;
  logic                r_trans;

  logic                w_run;
  logic                w_init_last;
  logic                w_sel_ok;
  logic                w_wr_bank_ok;
  logic                w_wr_accept;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [RGB_W-1:0]    w_mem_wdata;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_bypass;
  logic [RGB_W-1:0]    w_rd_data;
  logic                w_is_trans;

  assign w_run       = (r_state == ST_RUN);
  // The counter is the flat bank-major address, so the last entry is DEPTH-1.
  assign w_init_last = (r_init_cnt == ADDR_W'(DEPTH - 1));

  // Out-of-range bank numbers are possible when NUM_BANKS is not a power of two.
  assign w_sel_ok     = (int'(bus.bank_sel) < NUM_BANKS);
  assign w_wr_bank_ok = (int'(bus.wr_bank) < NUM_BANKS);

  // ---------------------------------------------------------------------------
  // Sequencer: INIT sweeps every entry once, then RUN forever.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        w_init_cnt_nxt = r_init_cnt + ADDR_W'(1);
        if (w_init_last) begin
          w_state_nxt    = ST_RUN;
          w_init_cnt_nxt = '0;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_ready    <= (w_state_nxt == ST_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Single write port shared between the init sweep and runtime writes.
  // ---------------------------------------------------------------------------
  assign w_wr_accept = w_run && bus.wr_en && w_wr_bank_ok;
  assign w_mem_we    = !w_run || w_wr_accept;
  assign w_mem_addr  = w_run ? ADDR_W'({bus.wr_bank, bus.wr_index}) : r_init_cnt;
  assign w_mem_wdata = w_run ? bus.wr_data : DEFAULT_RGB;

  // NOTE: the palette array has no reset; the init sweep fills it, which
  // keeps it mappable onto RAM.
  always_ff @(posedge Clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Bank selection: pending follows bank_sel, active loads at frame start.
  // A frame_start read still sees the old active bank because active_bank
  // only changes on this same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_active_bank  <= '0;
      r_pending_bank <= '0;
    end else if (w_run) begin
      if (w_sel_ok)        r_pending_bank <= bus.bank_sel;
      if (bus.frame_start) r_active_bank  <= r_pending_bank;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup: one-cycle registered read with write-through on a same-cycle hit.
  // ---------------------------------------------------------------------------
  assign w_rd_addr  = ADDR_W'({r_active_bank, bus.rd_index});
  assign w_bypass   = w_wr_accept && (bus.wr_bank == r_active_bank) &&
                      (bus.wr_index == bus.rd_index);
  assign w_rd_data  = w_bypass ? bus.wr_data : r_mem[w_rd_addr];
  assign w_is_trans = TRANS_EN && (bus.rd_index == IDX_W'(TRANSPARENT_IDX));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
      r_rgb       <= '0;
      r_trans     <= 1'b0;
    end else begin
      r_out_valid <= w_run && bus.rd_valid;
      // Colour and flag hold between requests.
      if (w_run && bus.rd_valid) begin
        r_rgb   <= w_rd_data;
        r_trans <= w_is_trans;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.red         = r_rgb[2*COMP_W +: COMP_W];
  assign bus.green       = r_rgb[COMP_W   +: COMP_W];
  assign bus.blue        = r_rgb[0        +: COMP_W];
  assign bus.transparent = r_trans;
  assign bus.wr_ready    = r_ready;
  assign bus.init_done   = r_ready;

endmodule
